// File: rtl/updn_hex_counter_if.sv
// Control/status bundle for the up/down hex counter.
// Ports: en, up, clear, load, load_val (to counter); count, tc, HEX (from counter).
// Latency: count/tc one edge after control; HEX one more edge. No backpressure (free-running).
interface updn_hex_counter_if #(
  parameter int WIDTH = 16
);
  localparam int HEX_DIGS = (WIDTH - 1) / 4 + 1;

  logic                    en;
  logic                    up;
  logic                    clear;
  logic                    load;
  logic [WIDTH-1:0]        load_val;
  logic [WIDTH-1:0]        count;
  logic                    tc;
  logic [7*HEX_DIGS-1:0]   HEX;

  // Controller side: drives the controls, observes the counter.
  modport master (
    output en, up, clear, load, load_val,
    input  count, tc, HEX
  );

  // Counter side.
  modport slave (
    input  en, up, clear, load, load_val,
    output count, tc, HEX
  );
endinterface

// File: rtl/updn_hex_counter.sv
// Prescaled up/down counter with clamped load, wrap pulse and registered 7-segment drive.
// Ports: clk, rst (sync, active-high), bus (slave modport: en/up/clear/load/load_val in; count/tc/HEX out).
// Latency: count/tc update on the step edge, HEX one edge later. No backpressure; en only gates progress.
module updn_hex_counter #(
  parameter int              WIDTH    = 16,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter int              TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  updn_hex_counter_if.slave   bus
);

  localparam int               HEX_DIGS = (WIDTH - 1) / 4 + 1;
  localparam int               PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]           pre_q,   pre_nxt;
  logic [WIDTH-1:0]        count_q, count_nxt;
  logic                    tc_q,    tc_nxt;
  logic [7*HEX_DIGS-1:0]   hex_q,   hex_nxt;
  logic                    step;
  logic [WIDTH-1:0]        load_clamped;
  logic [4*HEX_DIGS-1:0]   cnt_pad;

  // Active-low segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    step         = bus.en && (pre_q == PRE_LAST);
    load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;

    pre_nxt   = pre_q;
    count_nxt = count_q;
    tc_nxt    = 1'b0;   // tc is only ever a single-cycle pulse

    if (bus.clear) begin
      count_nxt = '0;
      pre_nxt   = '0;
    end else if (bus.load) begin
      count_nxt = load_clamped;
      pre_nxt   = '0;
    end else if (bus.en) begin
      pre_nxt = step ? '0 : pre_q + PW'(1);
      if (step) begin
        if (bus.up) begin
          // >= rather than == keeps count inside 0..MAX even from a stray state.
          if (count_q >= MAX_V) begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            count_nxt = MAX_V;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  // Zero-extend count to a whole number of nibbles so unused top-digit bits read 0.
  always_comb begin
    cnt_pad              = '0;
    cnt_pad[WIDTH-1:0]   = count_q;
    hex_nxt              = '0;
    for (int d = 0; d < HEX_DIGS; d++) begin
      hex_nxt[7*d +: 7] = seg7(cnt_pad[4*d +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      hex_q   <= {HEX_DIGS{7'h40}};
    end else begin
      pre_q   <= pre_nxt;
      count_q <= count_nxt;
      tc_q    <= tc_nxt;
      hex_q   <= hex_nxt;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.HEX   = hex_q;

endmodule

// File: tb/tb_updn_hex_counter.sv
// Directed bench for updn_hex_counter: three instances cover prescaled counting,
// wrap/clamp behaviour and enable gating; inputs change #1 after the rising edge,
// outputs are sampled at the same point.
module tb_updn_hex_counter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // A: WIDTH=8 MAX=255 TICK_DIV=3; B: WIDTH=8 MAX=9 TICK_DIV=1; C: WIDTH=6 MAX=63 TICK_DIV=4
  updn_hex_counter_if #(.WIDTH(8)) ia ();
  updn_hex_counter_if #(.WIDTH(8)) ib ();
  updn_hex_counter_if #(.WIDTH(6)) ic ();

  updn_hex_counter #(.WIDTH(8), .MAX(255), .TICK_DIV(3)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  updn_hex_counter #(.WIDTH(8), .MAX(9),   .TICK_DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  updn_hex_counter #(.WIDTH(6), .MAX(63),  .TICK_DIV(4)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  a_cnt [7];
    logic [6:0]  a_hex [7];

    a_cnt = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};
    a_hex = '{7'h40, 7'h40, 7'h40, 7'h79, 7'h79, 7'h79, 7'h24};

    rst = 1'b1;
    ia.en = 0; ia.up = 0; ia.clear = 0; ia.load = 0; ia.load_val = '0;
    ib.en = 0; ib.up = 0; ib.clear = 0; ib.load = 0; ib.load_val = '0;
    ic.en = 0; ic.up = 0; ic.clear = 0; ic.load = 0; ic.load_val = '0;
    tick();
    tick();

    // Reset state
    chk("rst_a_count", 32'(ia.count), 32'h0);
    chk("rst_a_tc",    32'(ia.tc),    32'h0);
    chk("rst_a_hex",   32'(ia.HEX),   32'({7'h40, 7'h40}));
    chk("rst_c_hex",   32'(ic.HEX),   32'({7'h40, 7'h40}));

    // Up count, TICK_DIV=3: step on every third edge, HEX one edge behind
    rst = 1'b0; ia.en = 1; ia.up = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("upcnt_count_%0d", i), 32'(ia.count), 32'(a_cnt[i]));
      chk($sformatf("upcnt_hex_%0d", i),   32'(ia.HEX),   32'({7'h40, a_hex[i]}));
      chk($sformatf("upcnt_tc_%0d", i),    32'(ia.tc),    32'h0);
    end
    // en=0 freezes count
    ia.en = 0;
    tick(); tick(); tick();
    chk("freeze_a_count", 32'(ia.count), 32'h2);
    chk("freeze_a_hex",   32'(ia.HEX),   32'({7'h40, 7'h24}));

    // Up wrap on B (MAX=9, TICK_DIV=1)
    ib.load_val = 8'd9; ib.load = 1;
    tick();
    chk("upwrap_load",   32'(ib.count), 32'd9);
    chk("upwrap_load_tc",32'(ib.tc),    32'h0);
    ib.load = 0; ib.en = 1; ib.up = 1;
    tick();
    chk("upwrap_count",  32'(ib.count), 32'd0);
    chk("upwrap_tc",     32'(ib.tc),    32'h1);
    chk("upwrap_hex9",   32'(ib.HEX),   32'({7'h40, 7'h18}));
    ib.en = 0;
    tick();
    chk("upwrap_tc_end", 32'(ib.tc),    32'h0);
    chk("upwrap_hex0",   32'(ib.HEX),   32'({7'h40, 7'h40}));
    chk("upwrap_hold",   32'(ib.count), 32'd0);

    // Down wrap on B
    ib.en = 1; ib.up = 0;
    tick();
    chk("dnwrap_count",  32'(ib.count), 32'd9);
    chk("dnwrap_tc",     32'(ib.tc),    32'h1);
    tick();
    chk("dnwrap2_count", 32'(ib.count), 32'd8);
    chk("dnwrap2_tc",    32'(ib.tc),    32'h0);
    ib.en = 0;

    // Load clamp, and clear beating load; en=1 must not matter
    ib.en = 1; ib.load_val = 8'h0F; ib.load = 1;
    tick();
    chk("clamp_count",   32'(ib.count), 32'd9);
    ib.load_val = 8'h03;
    tick();
    chk("load_inrange",  32'(ib.count), 32'd3);
    ib.clear = 1; ib.load_val = 8'h05;
    tick();
    chk("clr_over_load", 32'(ib.count), 32'd0);
    chk("clr_tc",        32'(ib.tc),    32'h0);
    ib.clear = 0; ib.load = 0; ib.en = 0;

    // Enable gating on C (TICK_DIV=4): drop en at pre=2 for 5 cycles
    ic.en = 1; ic.up = 1;
    tick(); tick();
    ic.en = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("gate_frozen_count", 32'(ic.count), 32'd0);
    chk("gate_frozen_tc",    32'(ic.tc),    32'h0);
    ic.en = 1;
    tick();
    chk("gate_resume1", 32'(ic.count), 32'd0);
    tick();
    chk("gate_resume2", 32'(ic.count), 32'd1);
    ic.en = 0;

    // C top digit of a 6-bit count: only two bits live, rest read 0
    ic.load_val = 6'h3F; ic.load = 1;
    tick();
    chk("c_load3f", 32'(ic.count), 32'h3F);
    ic.load = 0;
    tick();
    chk("c_hex3f",  32'(ic.HEX), 32'({7'h30, 7'h0E}));
    // Full 4-cycle wait after load, then wrap at MAX=63
    ic.en = 1; ic.up = 1;
    tick(); tick(); tick();
    chk("c_prewrap",    32'(ic.count), 32'h3F);
    tick();
    chk("c_wrap_count", 32'(ic.count), 32'h0);
    chk("c_wrap_tc",    32'(ic.tc),    32'h1);
    tick();
    chk("c_wrap_tcend", 32'(ic.tc),    32'h0);
    ic.en = 0;

    // Reset mid-operation on A with load asserted
    ia.en = 1;
    tick();
    rst = 1'b1; ia.load = 1; ia.load_val = 8'h55;
    tick();
    chk("midrst_count", 32'(ia.count), 32'h0);
    chk("midrst_hex",   32'(ia.HEX),   32'({7'h40, 7'h40}));
    chk("midrst_tc",    32'(ia.tc),    32'h0);
    rst = 1'b0; ia.load = 0; ia.up = 1;
    tick(); tick();
    chk("midrst_wait",  32'(ia.count), 32'h0);
    tick();
    chk("midrst_step",  32'(ia.count), 32'h1);

    // Direction change mid-prescale keeps pre
    tick();
    ia.up = 0;
    tick();
    chk("dir_hold",     32'(ia.count), 32'h1);
    tick();
    chk("dir_step_dn",  32'(ia.count), 32'h0);
    ia.en = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updn_hex_counter.md
UPDN_HEX_COUNTER -- requirements
Module: updn_hex_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter width in bits, legal range 1..32.
REQ-002 SHALL have parameter MAX, default 2**WIDTH-1: highest count value, legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter TICK_DIV, default 1: clock cycles per count step, legal range >=1.
REQ-004 SHALL have derived localparam HEX_DIGS = (WIDTH-1)/4+1: number of display digits.
REQ-005 SHALL use one clock `clk`; reset is `rst`, synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 en  input  1  count enable; gates both the prescaler and the count steps.
REQ-009 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-010 clear  input  1  synchronous clear to zero.
REQ-011 load  input  1  synchronous parallel load.
REQ-012 load_val  input  WIDTH  value to load.
REQ-013 count  output  WIDTH  registered count value.
REQ-014 tc  output  1  one-cycle terminal-count (wrap) pulse.
REQ-015 HEX  output  7*HEX_DIGS  registered segment drive; digit i occupies HEX[7i+6:7i].

Function
REQ-016 Prescaler: an internal counter pre runs 0..TICK_DIV-1, advances only when en=1, and produces step=1 in the cycle where en=1 and pre==TICK_DIV-1; pre then returns to 0.
REQ-017 TICK_DIV=1: step SHALL equal en every cycle.
REQ-018 en=0 SHALL freeze pre, count and HEX, and force tc=0.
REQ-019 Priority SHALL be rst > clear > load > step.
REQ-020 clear=1: count<=0, pre<=0, tc<=0, regardless of en.
REQ-021 load=1 (clear=0): count<=min(load_val, MAX), pre<=0, tc<=0, regardless of en.
REQ-022 step with up=1: count<MAX -> count+1, tc<=0; count==MAX -> count<=0, tc<=1.
REQ-023 step with up=0: count>0 -> count-1, tc<=0; count==0 -> count<=MAX, tc<=1.
REQ-024 Any cycle without a wrapping step SHALL drive tc=0, so tc never lasts more than one cycle.
REQ-025 Direction changes SHALL take effect on the next step; pre SHALL NOT be reset by a change of up.
REQ-026 HEX SHALL be registered, with one cycle of latency from count: HEX digit i shows count[4i+3:4i].
REQ-027 Bits of the top digit above WIDTH-1 SHALL read as 0.
REQ-028 Segment codes are active-low, with bit0 = segment a through bit6 = segment g:
  0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-029 No arithmetic overflow SHALL be visible: count SHALL always stay within 0..MAX.

Reset
REQ-030 rst=1 at a clock edge SHALL set count=0, pre=0 and tc=0, and set every HEX digit to 40 (glyph "0").
REQ-031 rst SHALL override clear, load and en in the same cycle.
REQ-032 rst asserted mid-prescale or mid-count SHALL discard all progress.
REQ-033 Counting SHALL resume on the first edge after rst deasserts, with a full TICK_DIV-cycle wait before the first step.
REQ-034 Outputs before the first reset are undefined and are not checked.

Verification
REQ-035 Scenario "up count" (WIDTH=8, MAX=255, TICK_DIV=3): rst, then en=1 up=1 -> count increments on every third cycle; HEX shows 00,01,02 with one cycle of lag behind count.
REQ-036 Scenario "up wrap" (MAX=9, TICK_DIV=1): load 9, then one step with up=1 -> count=0 and tc=1 for exactly one cycle; HEX low digit goes 18 -> 40.
REQ-037 Scenario "down wrap" (MAX=9): count=0, up=0, step -> count=9 and tc=1; next step -> count=8 and tc=0.
REQ-038 Scenario "load clamp" (MAX=9): load_val=0x0F with load=1 -> count=9; load and clear asserted together -> count=0.
REQ-039 Scenario "enable gating" (TICK_DIV=4): en drops at pre=2 and returns 5 cycles later -> the next step comes exactly 2 enabled cycles after en returns.
REQ-040 Scenario "reset mid-operation": rst asserted during counting with load=1 -> count=0 and HEX=40 per digit; the first step comes TICK_DIV cycles after rst falls.
